line_cache_writeback: RTL and testbench

LINE_CACHE_WRITEBACK -- requirements
Module: line_cache_writeback

---
 rtl/line_cache_writeback.sv | 277 +++++++++++++++++++++++++++
 tb/tb_line_cache_writeback.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_cache_writeback.sv
// ---------------------------------------------------------------------------
// line_cache_writeback
//
// Copies one finished row out of a two-half line cache into SDRAM as a series
// of fixed-length write bursts. The frame sampler, in another clock domain,
// signals each finished row by toggling s_req. This block answers by setting
// s_ack equal to the served request value once the whole row is written.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   s_req        row-ready toggle (async, synchronized here)
//   s_cache_row  line-cache half holding the row (async, synchronized here)
//   s_sdram_row  destination SDRAM row {line[8:0], field} (async, synchronized)
//   s_ack        acknowledge toggle
//   rd_address   line-cache read address {cache_row, word_index[9:0]}
//   rd_data      line-cache read data, valid one cycle after rd_address
//   cmd_valid    burst write command valid
//   cmd_ready    command accepted when cmd_valid && cmd_ready
//   cmd_addr     {sdram_row[9:0], column[9:0]}, column = burst * BURST_LEN
//   wd_valid     write data beat valid
//   wd_ready     beat accepted when wd_valid && wd_ready
//   wd_data      write data beat
//   busy         high from request capture until s_ack toggles
//   overrun      one-cycle pulse when the destination row changes while busy
// ---------------------------------------------------------------------------
module line_cache_writeback #(
    parameter int ROW_WORDS = 752,  // words per row, multiple of BURST_LEN
    parameter int BURST_LEN = 8     // words per burst, power of two
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_req,
    input  logic        s_cache_row,
    input  logic [9:0]  s_sdram_row,
    output logic        s_ack,
    output logic [10:0] rd_address,
    input  logic [15:0] rd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [19:0] cmd_addr,
    output logic        wd_valid,
    input  logic        wd_ready,
    output logic [15:0] wd_data,
    output logic        busy,
    output logic        overrun
);

    localparam int NUM_BURSTS = ROW_WORDS / BURST_LEN;
    localparam int BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [9:0]         LAST_WORD  = 10'(ROW_WORDS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_CMD    = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;

    // -----------------------------------------------------------------------
    // Two-flop synchronizers for the request bundle. The bits may land on
    // different cycles; SETTLE waits one extra cycle after the request is
    // seen so the row fields have caught up before they are latched.
    // -----------------------------------------------------------------------
    logic [11:0] sync1_q, sync2_q;
    logic        req_s;
    logic        cache_row_s;
    logic [9:0]  sdram_row_s;

    // NOTE: every register is written with <= so all flops sample the values
    // from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {s_req, s_cache_row, s_sdram_row};
            sync2_q <= sync1_q;
        end
    end

    assign req_s       = sync2_q[11];
    assign cache_row_s = sync2_q[10];
    assign sdram_row_s = sync2_q[9:0];

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]         state_q,      state_d;
    logic               ack_q,        ack_d;
    logic               busy_q,       busy_d;
    logic               overrun_q,    overrun_d;
    logic               req_val_q,    req_val_d;
    logic               cache_row_q,  cache_row_d;
    logic [9:0]         sdram_row_q,  sdram_row_d;
    logic [9:0]         sdram_prev_q, sdram_prev_d;
    logic [BURST_W-1:0] burst_q,      burst_d;
    logic [BEAT_W-1:0]  beat_q,       beat_d;
    logic [9:0]         rd_idx_q,     rd_idx_d;   // word index on rd_address
    logic               rd_done_q,    rd_done_d;  // every word of the row read
    logic               rd_pend_q,    rd_pend_d;  // rd_data this cycle is wanted
    logic [15:0]        buf0_q,       buf0_d;     // skid head, drives wd_data
    logic [15:0]        buf1_q,       buf1_d;
    logic [1:0]         count_q,      count_d;

    logic fetch_active;
    logic beat_fire;
    logic rd_issue;
    logic [2:0] occupancy;

    assign cmd_valid  = (state_q == ST_CMD);
    assign wd_valid   = (state_q == ST_DATA) && (count_q != 2'd0);
    assign wd_data    = buf0_q;
    assign rd_address = {cache_row_q, rd_idx_q};
    assign cmd_addr   = {sdram_row_q, 10'(burst_q * BURST_LEN)};
    assign s_ack      = ack_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

    assign beat_fire    = wd_valid && wd_ready;
    assign fetch_active = (state_q == ST_CMD) || (state_q == ST_DATA);

    // Buffer occupancy after this cycle's pop, counting the read in flight.
    // A full buffer that is draining this cycle still has room for one more
    // read, which keeps beats back-to-back across a stall or a CMD gap.
    assign occupancy = 3'(count_q) + 3'(rd_pend_q) - 3'(beat_fire);
    assign rd_issue  = fetch_active && !rd_done_q && (occupancy < 3'd2);

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        busy_d       = busy_q;
        req_val_d    = req_val_q;
        cache_row_d  = cache_row_q;
        sdram_row_d  = sdram_row_q;
        burst_d      = burst_q;
        beat_d       = beat_q;
        rd_idx_d     = rd_idx_q;
        rd_done_d    = rd_done_q;
        rd_pend_d    = 1'b0;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        count_d      = count_q;
        sdram_prev_d = sdram_row_s;
        overrun_d    = busy_q && (sdram_row_s != sdram_prev_q);

        // Cache read side: present the next word and advance, stopping on
        // the last word of the row so the address never wraps.
        if (rd_issue) begin
            rd_pend_d = 1'b1;
            if (rd_idx_q == LAST_WORD) begin
                rd_done_d = 1'b1;
            end else begin
                rd_idx_d = rd_idx_q + 10'd1;
            end
        end

        // Skid buffer: push the word returned this cycle, pop on an accepted
        // beat. buf0 only changes on a pop or when empty, so wd_data holds
        // steady through a stall.
        case ({rd_pend_q, beat_fire})
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = rd_data;
                end else begin
                    buf1_d = rd_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rd_data;
                end
            end
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (req_s != ack_q) begin
                    state_d = ST_SETTLE;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                req_val_d   = req_s;
                cache_row_d = cache_row_s;
                sdram_row_d = sdram_row_s;
                burst_d     = '0;
                beat_d      = '0;
                rd_idx_d    = '0;
                rd_done_d   = 1'b0;
                count_d     = 2'd0;
                state_d     = ST_CMD;
            end
            ST_CMD: begin
                if (cmd_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_fire) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (burst_q == LAST_BURST) begin
                            state_d = ST_ACK;
                        end else begin
                            burst_d = burst_q + 1'b1;
                            state_d = ST_CMD;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                ack_d   = req_val_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the two skid entries are reset along with the control state; they
    // are plain flops, and a defined wd_data after reset costs nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            req_val_q    <= 1'b0;
            cache_row_q  <= 1'b0;
            sdram_row_q  <= '0;
            sdram_prev_q <= '0;
            burst_q      <= '0;
            beat_q       <= '0;
            rd_idx_q     <= '0;
            rd_done_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            req_val_q    <= req_val_d;
            cache_row_q  <= cache_row_d;
            sdram_row_q  <= sdram_row_d;
            sdram_prev_q <= sdram_prev_d;
            burst_q      <= burst_d;
            beat_q       <= beat_d;
            rd_idx_q     <= rd_idx_d;
            rd_done_q    <= rd_done_d;
            rd_pend_q    <= rd_pend_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_line_cache_writeback.sv
// ---------------------------------------------------------------------------
// tb_line_cache_writeback
//
// Bench for line_cache_writeback at default parameters. A line-cache model
// answers reads one cycle later. Each request pushes its expected commands
// and beats onto scoreboard queues; a monitor pops and compares them on every
// handshake. One task per scenario.
// ---------------------------------------------------------------------------
module tb_line_cache_writeback;

    localparam int ROW_WORDS  = 752;
    localparam int BURST_LEN  = 8;
    localparam int NUM_BURSTS = ROW_WORDS / BURST_LEN;

    logic        clk;
    logic        reset;
    logic        s_req;
    logic        s_cache_row;
    logic [9:0]  s_sdram_row;
    logic        s_ack;
    logic [10:0] rd_address;
    logic [15:0] rd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] cmd_addr;
    logic        wd_valid;
    logic        wd_ready;
    logic [15:0] wd_data;
    logic        busy;
    logic        overrun;

    logic [15:0] cache [0:2047];

    int errors;
    int checks;
    int cmd_cnt;
    int beat_cnt;
    int ovr_cnt;

    logic [19:0] exp_cmd  [$];
    logic [15:0] exp_beat [$];

    line_cache_writeback dut (
        .clk         (clk),
        .reset       (reset),
        .s_req       (s_req),
        .s_cache_row (s_cache_row),
        .s_sdram_row (s_sdram_row),
        .s_ack       (s_ack),
        .rd_address  (rd_address),
        .rd_data     (rd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .wd_valid    (wd_valid),
        .wd_ready    (wd_ready),
        .wd_data     (wd_data),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line-cache model: data for the address presented in one cycle appears
    // in the next.
    always @(posedge clk) rd_data <= cache[rd_address];

    // Scoreboard monitor, sampling on the falling edge.
    task automatic monitor();
        logic        stall_q    = 1'b0;
        logic [15:0] stall_data = '0;
        logic [19:0] ec;
        logic [15:0] eb;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_q = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    checks++;
                    cmd_cnt++;
                    if (exp_cmd.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_extra: got cmd_addr=%h, none expected", cmd_addr);
                    end else begin
                        ec = exp_cmd.pop_front();
                        if (cmd_addr !== ec) begin
                            errors++;
                            $display("FAIL cmd_addr: got %h expected %h", cmd_addr, ec);
                        end
                    end
                end
                if (stall_q) begin
                    checks++;
                    if (wd_valid !== 1'b1 || wd_data !== stall_data) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                                 wd_valid, wd_data, stall_data);
                    end
                end
                stall_q    = wd_valid && !wd_ready;
                stall_data = wd_data;
                if (wd_valid && wd_ready) begin
                    checks++;
                    beat_cnt++;
                    if (exp_beat.size() == 0) begin
                        errors++;
                        $display("FAIL beat_extra: got wd_data=%h, none expected", wd_data);
                    end else begin
                        eb = exp_beat.pop_front();
                        if (wd_data !== eb) begin
                            errors++;
                            $display("FAIL beat_data: got %h expected %h (beat %0d)", wd_data, eb, beat_cnt);
                        end
                    end
                end
                if (overrun) ovr_cnt++;
            end
        end
    endtask

    // Set the row fields a cycle ahead, then toggle s_req and queue the
    // expected commands and beats for the whole row.
    task automatic start_req(input logic row, input logic [9:0] srow);
        @(posedge clk); #1;
        s_cache_row = row;
        s_sdram_row = srow;
        @(posedge clk); #1;
        for (int b = 0; b < NUM_BURSTS; b++) exp_cmd.push_back({srow, 10'(b * BURST_LEN)});
        for (int w = 0; w < ROW_WORDS; w++) exp_beat.push_back(cache[{row, 10'(w)}]);
        s_req = ~s_req;
    endtask

    task automatic wait_ack(input logic val, input int budget, input bit rnd,
                            output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = budget;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) wd_ready = 1'($urandom_range(0, 1));
            if (s_ack === val) begin
                ok  = 1'b1;
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic check_done(input string name, input bit ok, input int c0, input int b0);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: s_ack=%b never reached s_req=%b", name, s_ack, s_req);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got %b expected 0", name, busy);
        end
        checks++;
        if (exp_cmd.size() != 0 || exp_beat.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: cmds=%0d beats=%0d still expected", name, exp_cmd.size(), exp_beat.size());
        end
        checks++;
        if (cmd_cnt - c0 != NUM_BURSTS || beat_cnt - b0 != ROW_WORDS) begin
            errors++;
            $display("FAIL %s_counts: got cmds=%0d beats=%0d expected %0d/%0d",
                     name, cmd_cnt - c0, beat_cnt - b0, NUM_BURSTS, ROW_WORDS);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_ack, busy, overrun, cmd_valid, wd_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got ack/busy/ovr/cmdv/wdv=%b expected 00000",
                     {s_ack, busy, overrun, cmd_valid, wd_valid});
        end
        checks++;
        if (rd_address !== 11'd0 || cmd_addr !== 20'd0) begin
            errors++;
            $display("FAIL reset_addr: got rd=%h cmd=%h expected 0/0", rd_address, cmd_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b cmd_valid=%b expected 0/0", busy, cmd_valid);
        end
    endtask

    task automatic test_basic();
        bit ok; int cyc; int c0 = cmd_cnt; int b0 = beat_cnt; int o0 = ovr_cnt;
        start_req(1'b1, 10'h0A5);
        wait_ack(s_req, 3000, 1'b0, ok, cyc);
        check_done("basic", ok, c0, b0);
        checks++;
        if (s_ack !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack: got %b expected 1", s_ack);
        end
        // Back-to-back beats give one command cycle plus BURST_LEN beats per
        // burst; a bubble per burst would blow this bound.
        checks++;
        if (cyc > 870) begin
            errors++;
            $display("FAIL basic_throughput: got %0d cycles expected at most 870", cyc);
        end
        checks++;
        if (ovr_cnt != o0) begin
            errors++;
            $display("FAIL basic_overrun: got %0d pulses expected 0", ovr_cnt - o0);
        end
    endtask

    task automatic test_random_ready();
        bit ok; int cyc; int c0 = cmd_cnt; int b0 = beat_cnt;
        start_req(1'b0, 10'h123);
        wait_ack(s_req, 6000, 1'b1, ok, cyc);
        wd_ready = 1'b1;
        check_done("random_ready", ok, c0, b0);
    endtask

    task automatic test_cmd_hold();
        bit ok; int cyc; bit seen = 1'b0; int c0 = cmd_cnt; int b0 = beat_cnt;
        cmd_ready = 1'b0;
        start_req(1'b1, 10'h0AA);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cmd_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hold_cmd_valid: got no cmd_valid within 20 cycles");
        end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || cmd_addr !== {10'h0AA, 10'h000} || wd_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d got valid=%b addr=%h wd_valid=%b expected 1/%h/0",
                         i, cmd_valid, cmd_addr, wd_valid, {10'h0AA, 10'h000});
            end
        end
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        wait_ack(s_req, 3000, 1'b0, ok, cyc);
        check_done("cmd_hold", ok, c0, b0);
    endtask

    task automatic test_overrun();
        bit ok; int cyc; bit hit = 1'b0; int c0 = cmd_cnt; int b0 = beat_cnt; int o0 = ovr_cnt;
        start_req(1'b1, 10'h0A5);
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk); #1;
            hit = (cmd_cnt - c0 >= 10);
        end
        s_sdram_row = 10'h0A6;
        wait_ack(s_req, 3000, 1'b0, ok, cyc);
        check_done("overrun", ok, c0, b0);
        checks++;
        if (ovr_cnt - o0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; bit rebusy = 1'b0;
        int c0 = cmd_cnt; int b0 = beat_cnt; int o0 = ovr_cnt;
        start_req(1'b1, 10'h0A5);
        repeat (100) @(posedge clk);
        start_req(1'b0, 10'h0A5);
        wait_ack(1'b1, 3000, 1'b0, ok, cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_first_ack: got s_ack=%b expected 1", s_ack);
        end
        for (int i = 0; i < 4 && !rebusy; i++) begin
            @(posedge clk); #1;
            rebusy = busy;
        end
        checks++;
        if (!rebusy) begin
            errors++;
            $display("FAIL b2b_restart: got busy=0 expected 1 within 4 cycles of first ack");
        end
        wait_ack(1'b0, 3000, 1'b0, ok, cyc);
        checks++;
        if (!ok || s_ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final_ack: got s_ack=%b expected 0", s_ack);
        end
        checks++;
        if (exp_cmd.size() != 0 || exp_beat.size() != 0 ||
            cmd_cnt - c0 != 2 * NUM_BURSTS || beat_cnt - b0 != 2 * ROW_WORDS) begin
            errors++;
            $display("FAIL b2b_counts: got cmds=%0d beats=%0d expected %0d/%0d",
                     cmd_cnt - c0, beat_cnt - b0, 2 * NUM_BURSTS, 2 * ROW_WORDS);
        end
        checks++;
        if (ovr_cnt != o0) begin
            errors++;
            $display("FAIL b2b_overrun: got %0d pulses expected 0", ovr_cnt - o0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc; bit hit = 1'b0; bit seen = 1'b0; int b0 = beat_cnt; int c0;
        start_req(1'b1, 10'h0A5);
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk); #1;
            hit = (beat_cnt - b0 >= 300);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reach: got %0d beats expected 300", beat_cnt - b0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({s_ack, busy, overrun, cmd_valid, wd_valid} !== 5'b0 ||
            rd_address !== 11'd0 || cmd_addr !== 20'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags=%b rd=%h cmd=%h expected 0",
                     {s_ack, busy, overrun, cmd_valid, wd_valid}, rd_address, cmd_addr);
        end
        exp_cmd.delete();
        exp_beat.delete();
        s_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b0 || wd_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_quiet: cycle %0d got cmdv=%b wdv=%b busy=%b expected 0",
                         i, cmd_valid, wd_valid, busy);
            end
        end
        c0 = cmd_cnt;
        b0 = beat_cnt;
        start_req(1'b0, 10'h155);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cmd_valid;
        end
        checks++;
        if (!seen || cmd_addr !== {10'h155, 10'h000}) begin
            errors++;
            $display("FAIL mid_restart_col: got valid=%b addr=%h expected 1/%h",
                     cmd_valid, cmd_addr, {10'h155, 10'h000});
        end
        wait_ack(s_req, 3000, 1'b0, ok, cyc);
        check_done("reset_mid", ok, c0, b0);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        cmd_cnt     = 0;
        beat_cnt    = 0;
        ovr_cnt     = 0;
        reset       = 1'b1;
        s_req       = 1'b0;
        s_cache_row = 1'b0;
        s_sdram_row = '0;
        cmd_ready   = 1'b1;
        wd_ready    = 1'b1;
        for (int i = 0; i < 2048; i++) cache[i] = 16'($urandom);

        fork
            monitor();
        join_none

        test_reset();
        test_basic();
        test_random_ready();
        test_cmd_hold();
        test_overrun();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
